// File: rtl/master_burst_out_port.sv
// Master transmit port: arbitrates for the serial bus, sends the slave/address/burst
// header LSB-first, then streams write words or waits for the read to complete.
module master_burst_out_port #(
  parameter int SLAVE_LEN   = 2,
  parameter int ADDRESS_LEN = 12,
  parameter int WORD_SIZE   = 8,
  parameter int BURST_SIZE  = 12,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             instruction,
  input  logic [SLAVE_LEN-1:0]   slave_select,
  input  logic [ADDRESS_LEN-1:0] address,
  input  logic [BURST_SIZE-1:0]  burst_num,
  input  logic [WORD_SIZE-1:0]   data,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   approval_request,
  input  logic                   approval_grant,
  input  logic                   arbitor_busy,
  input  logic                   slave_ready,
  input  logic                   split_en,
  input  logic                   rx_done,
  output logic                   master_ready,
  output logic                   bus_busy,
  output logic                   master_valid,
  output logic                   write_en,
  output logic                   read_en,
  output logic                   tx_slave_select,
  output logic                   tx_address,
  output logic                   tx_burst_num,
  output logic                   tx_data,
  output logic                   tx_done,
  output logic                   timeout_err
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_REQ        = 4'd1;
  localparam logic [3:0] S_SEL        = 4'd2;
  localparam logic [3:0] S_WAIT_SLAVE = 4'd3;
  localparam logic [3:0] S_SPLIT      = 4'd4;
  localparam logic [3:0] S_ADDR       = 4'd5;
  localparam logic [3:0] S_DATA       = 4'd6;
  localparam logic [3:0] S_RD_WAIT    = 4'd7;
  localparam logic [3:0] S_DONE       = 4'd8;

  localparam int MAXLEN = (ADDRESS_LEN > WORD_SIZE)
                        ? ((ADDRESS_LEN > SLAVE_LEN) ? ADDRESS_LEN : SLAVE_LEN)
                        : ((WORD_SIZE > SLAVE_LEN) ? WORD_SIZE : SLAVE_LEN);
  localparam int CW = $clog2(MAXLEN);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] SEL_LAST  = CW'(SLAVE_LEN - 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRESS_LEN - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(WORD_SIZE - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);

  logic [3:0]             state;
  logic [1:0]             instr_q;
  logic [SLAVE_LEN-1:0]   sel_q, sel_sh;
  logic [ADDRESS_LEN-1:0] addr_q, addr_sh, burst_sh;
  logic [BURST_SIZE-1:0]  burst_q;
  logic [WORD_SIZE-1:0]   data_sh;
  logic [CW-1:0]          cnt;
  logic [TW-1:0]          wait_cnt;
  logic [BURST_SIZE:0]    word_cnt, words_total;
  logic                   shifting, last_bit, on_bus, is_write;

  // Extra MSB lets an all-ones burst_num request 2^BURST_SIZE words without wrapping.
  assign words_total = {1'b0, burst_q} + (BURST_SIZE+1)'(1);
  assign is_write    = (instr_q == 2'b10);
  assign on_bus      = (state == S_SEL) || (state == S_WAIT_SLAVE) || (state == S_ADDR) ||
                       (state == S_DATA) || (state == S_RD_WAIT) || (state == S_DONE);
  assign last_bit    = shifting && (cnt == WORD_LAST);

  assign master_ready     = (state == S_IDLE);
  assign approval_request = ((state == S_REQ) && !arbitor_busy) || on_bus;
  assign bus_busy         = on_bus;
  assign write_en         = on_bus && is_write;
  assign read_en          = on_bus && !is_write;
  assign master_valid     = (state == S_SEL) || (state == S_ADDR) || ((state == S_DATA) && shifting);
  assign tx_slave_select  = (state == S_SEL) && sel_sh[0];
  assign tx_address       = (state == S_ADDR) && addr_sh[0];
  assign tx_burst_num     = (state == S_ADDR) && burst_sh[0];
  assign tx_data          = (state == S_DATA) && shifting && data_sh[0];
  assign tx_done          = (state == S_DONE);
  // The next word may be taken on the last bit of the current one, giving gapless bursts.
  assign data_ready       = (state == S_DATA) && data_valid && (!shifting || last_bit) &&
                            (word_cnt != words_total);

  // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      sel_q       <= '0;
      sel_sh      <= '0;
      addr_q      <= '0;
      addr_sh     <= '0;
      burst_q     <= '0;
      burst_sh    <= '0;
      data_sh     <= '0;
      cnt         <= '0;
      wait_cnt    <= '0;
      word_cnt    <= '0;
      shifting    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (instruction == 2'b10 || instruction == 2'b01)) begin
            instr_q  <= instruction;
            sel_q    <= slave_select;
            addr_q   <= address;
            burst_q  <= burst_num;
            wait_cnt <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (approval_grant) begin
            sel_sh <= sel_q;
            cnt    <= '0;
            state  <= S_SEL;
          end else if (wait_cnt == T_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_SEL: begin
          sel_sh <= sel_sh >> 1;
          if (cnt == SEL_LAST) begin
            wait_cnt <= '0;
            state    <= S_WAIT_SLAVE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_SLAVE: begin
          if (split_en) begin
            state <= S_SPLIT;
          end else if (slave_ready) begin
            addr_sh  <= addr_q;
            burst_sh <= ADDRESS_LEN'(burst_q);
            cnt      <= '0;
            state    <= S_ADDR;
          end else if (wait_cnt == T_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_SPLIT: begin
          if (!split_en) begin
            wait_cnt <= '0;
            state    <= S_REQ;
          end
        end
        S_ADDR: begin
          addr_sh  <= addr_sh >> 1;
          burst_sh <= burst_sh >> 1;
          if (cnt == ADDR_LAST) begin
            cnt      <= '0;
            shifting <= 1'b0;
            word_cnt <= '0;
            state    <= is_write ? S_DATA : S_RD_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (data_ready) begin
            data_sh  <= data;
            shifting <= 1'b1;
            cnt      <= '0;
            word_cnt <= word_cnt + (BURST_SIZE+1)'(1);
          end else if (shifting) begin
            data_sh <= data_sh >> 1;
            if (last_bit) begin
              shifting <= 1'b0;
              if (word_cnt == words_total) state <= S_DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_RD_WAIT: begin
          if (rx_done) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_burst_out_port.sv
// Directed bench for master_burst_out_port: write, burst, read, timeout, split and
// mid-burst reset scenarios with hand-computed serial patterns.
module tb_master_burst_out_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  instruction = 2'b00;
  logic [1:0]  slave_select = '0;
  logic [11:0] address = '0;
  logic [11:0] burst_num = '0;
  logic [7:0]  data = '0;
  logic        data_valid = 1'b0;
  logic        approval_grant = 1'b0;
  logic        arbitor_busy = 1'b0;
  logic        slave_ready = 1'b0;
  logic        split_en = 1'b0;
  logic        rx_done = 1'b0;
  logic        data_ready, approval_request, master_ready, bus_busy, master_valid;
  logic        write_en, read_en, tx_slave_select, tx_address, tx_burst_num, tx_data;
  logic        tx_done, timeout_err;

  master_burst_out_port dut (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .slave_select(slave_select), .address(address), .burst_num(burst_num),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .approval_request(approval_request), .approval_grant(approval_grant),
    .arbitor_busy(arbitor_busy), .slave_ready(slave_ready), .split_en(split_en),
    .rx_done(rx_done), .master_ready(master_ready), .bus_busy(bus_busy),
    .master_valid(master_valid), .write_en(write_en), .read_en(read_en),
    .tx_slave_select(tx_slave_select), .tx_address(tx_address),
    .tx_burst_num(tx_burst_num), .tx_data(tx_data), .tx_done(tx_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (tx_done) done_cnt++;

  logic [1:0]  sel_cap;
  logic [11:0] addr_cap, burst_cap;
  logic [63:0] bits;
  int          nbits, rdy_n, done_at, hdr_bad, bad;
  int          rdy_at[8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [1:0] ins, input logic [1:0] sel,
                          input logic [11:0] adr, input logic [11:0] bn);
    instruction = ins; slave_select = sel; address = adr; burst_num = bn; start = 1'b1;
    cyc();
    start = 1'b0; instruction = 2'b00; slave_select = '0; address = '0; burst_num = '0;
  endtask

  task automatic grant_after(input int n);
    approval_grant = 1'b0;
    repeat (n) cyc();
    approval_grant = 1'b1;
    cyc();
    approval_grant = 1'b0;
  endtask

  task automatic cap_sel();
    for (int i = 0; i < 2; i++) begin
      #1;
      sel_cap[i] = tx_slave_select;
      if (!master_valid) hdr_bad++;
      cyc();
    end
  endtask

  task automatic pass_wait();
    slave_ready = 1'b1;
    #1;
    if (master_valid) hdr_bad++;
    cyc();
    slave_ready = 1'b0;
  endtask

  task automatic cap_addr();
    for (int i = 0; i < 12; i++) begin
      #1;
      addr_cap[i]  = tx_address;
      burst_cap[i] = tx_burst_num;
      if (!master_valid) hdr_bad++;
      cyc();
    end
  endtask

  // Feeds words with data_valid high; records data_ready cycles, serial bits and the
  // tx_done cycle, all relative to the first DATA cycle.
  task automatic run_data(input int nw, input logic [31:0] words, input int rst_at);
    int idx = 0;
    rdy_n = 0; nbits = 0; bits = '0; done_at = -1;
    for (int c = 0; c < 200; c++) begin
      if (c == rst_at) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        break;
      end
      if (idx < nw) begin
        data_valid = 1'b1;
        data = words[8*idx +: 8];
      end else begin
        data_valid = 1'b0;
        data = '0;
      end
      #1;
      if (tx_done) begin
        done_at = c;
        break;
      end
      if (master_valid && nbits < 64) begin
        bits[nbits] = tx_data;
        nbits++;
      end
      if (data_ready) begin
        if (rdy_n < 8) rdy_at[rdy_n] = c;
        rdy_n++;
        idx++;
      end
      cyc();
    end
    data_valid = 1'b0;
    data = '0;
  endtask

  task automatic single_write(input string tag);
    send_cmd(2'b10, 2'b01, 12'h005, 12'h000);
    #1;
    check({tag, "_ready_low"}, master_ready, 1'b0);
    grant_after(1);
    #1;
    check({tag, "_wr_en_sel"}, {write_en, read_en, bus_busy}, 3'b101);
    hdr_bad = 0;
    cap_sel();
    pass_wait();
    cap_addr();
    check({tag, "_sel_bits"}, sel_cap, 2'b01);
    check({tag, "_addr_bits"}, addr_cap, 12'h005);
    check({tag, "_burst_bits"}, burst_cap, 12'h000);
    check({tag, "_hdr_valid"}, hdr_bad, 0);
    run_data(1, 32'h0000_00A5, -1);
    check({tag, "_data_bits"}, {nbits, bits[31:0]}, {32'd8, 32'h0000_00A5});
    check({tag, "_ready_pulses"}, {rdy_n, rdy_at[0]}, {32'd1, 32'd0});
    check({tag, "_done_at"}, done_at, 9);
    cyc();
    #1;
    check({tag, "_after"}, {write_en, master_ready, tx_done, bus_busy}, 4'b0100);
  endtask

  initial begin
    int d0, n;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check("reset_state",
          {master_ready, approval_request, bus_busy, master_valid, write_en, read_en,
           tx_slave_select, tx_address, tx_burst_num, tx_data, tx_done, timeout_err, data_ready},
          13'b1_0000_0000_0000);
    cyc();

    // Invalid instruction is ignored
    send_cmd(2'b11, 2'b01, 12'h001, 12'h000);
    #1;
    check("ignore_instr_11", {master_ready, approval_request}, 2'b10);

    d0 = done_cnt;
    single_write("wr1");
    check("wr1_done_count", done_cnt - d0, 1);

    // Four-word burst with data_valid held high
    send_cmd(2'b10, 2'b00, 12'h100, 12'h003);
    grant_after(0);
    hdr_bad = 0;
    cap_sel();
    pass_wait();
    cap_addr();
    check("burst_hdr", {sel_cap, addr_cap, burst_cap}, {2'b00, 12'h100, 12'h003});
    run_data(4, 32'h0403_0201, -1);
    check("burst_ready_count", rdy_n, 4);
    check("burst_ready_spacing", {rdy_at[0], rdy_at[1], rdy_at[2], rdy_at[3]},
          {32'd0, 32'd8, 32'd16, 32'd24});
    check("burst_bits", {nbits, bits[31:0]}, {32'd32, 32'h0403_0201});
    check("burst_done_at", done_at, 33);
    cyc();

    // Read: read_en from SEL through DONE, no data bits
    send_cmd(2'b01, 2'b11, 12'hFFF, 12'h005);
    grant_after(0);
    #1;
    check("rd_en_sel", {read_en, write_en}, 2'b10);
    hdr_bad = 0;
    cap_sel();
    pass_wait();
    cap_addr();
    check("rd_hdr", {sel_cap, addr_cap, burst_cap, hdr_bad[3:0]}, {2'b11, 12'hFFF, 12'h005, 4'h0});
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!read_en || tx_data || master_valid || tx_done || data_ready) bad++;
      cyc();
    end
    check("rd_wait_quiet", bad, 0);
    rx_done = 1'b1;
    #1;
    check("rd_no_early_done", tx_done, 1'b0);
    cyc();
    rx_done = 1'b0;
    #1;
    check("rd_done", {tx_done, read_en}, 2'b11);
    cyc();
    #1;
    check("rd_after", {read_en, master_ready, tx_done}, 3'b010);

    // Grant timeout, with arbitor_busy gating the request at first
    send_cmd(2'b10, 2'b01, 12'h010, 12'h000);
    arbitor_busy = 1'b1;
    #1;
    check("req_gated_by_busy", approval_request, 1'b0);
    arbitor_busy = 1'b0;
    #1;
    check("req_raised", approval_request, 1'b1);
    n = 1;
    while (!timeout_err && n < 40) begin
      cyc();
      n++;
      #1;
    end
    check("grant_timeout_cycle", n, 17);
    check("grant_timeout_state", {timeout_err, approval_request, master_ready}, 3'b101);
    cyc();
    #1;
    check("timeout_pulse_width", timeout_err, 1'b0);

    // Split during WAIT_SLAVE (wins over slave_ready), then retry with full header
    d0 = done_cnt;
    send_cmd(2'b10, 2'b10, 12'h3C5, 12'h000);
    grant_after(0);
    hdr_bad = 0;
    cap_sel();
    check("split_sel_first", sel_cap, 2'b10);
    split_en = 1'b1;
    slave_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        #1;
        if (approval_request || bus_busy || write_en || master_valid) bad++;
      end
      cyc();
      slave_ready = 1'b0;
    end
    split_en = 1'b0;
    #1;
    if (approval_request || bus_busy || write_en) bad++;
    check("split_drops_bus", bad, 0);
    cyc();
    #1;
    check("split_back_to_req", {approval_request, master_ready}, 2'b10);
    sel_cap = '0;
    grant_after(1);
    cap_sel();
    pass_wait();
    cap_addr();
    check("split_hdr_resent", {sel_cap, addr_cap, burst_cap, hdr_bad[3:0]},
          {2'b10, 12'h3C5, 12'h000, 4'h0});
    run_data(1, 32'h0000_005A, -1);
    check("split_data", {nbits, bits[7:0], done_at}, {32'd8, 8'h5A, 32'd9});
    cyc();
    check("split_single_done", done_cnt - d0, 1);

    // Reset during the second word of a four-word burst
    send_cmd(2'b10, 2'b01, 12'h020, 12'h003);
    grant_after(0);
    cap_sel();
    pass_wait();
    cap_addr();
    run_data(4, 32'h4433_2211, 12);
    #1;
    check("midburst_reset",
          {master_ready, approval_request, bus_busy, master_valid, write_en, read_en,
           tx_slave_select, tx_address, tx_burst_num, tx_data, tx_done, timeout_err, data_ready},
          13'b1_0000_0000_0000);
    cyc();
    d0 = done_cnt;
    single_write("wr2");
    check("wr2_done_count", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/master_burst_out_port.md
Name: master_burst_out_port

Overview:
- Next-generation master transmit port for the serial bus.
- Takes a parallel command (instruction, slave select, address, burst count, write data words) from the master core.
- Obtains the bus from the arbiter and serialises fields LSB-first on dedicated 1-bit lines.
- New over the single-word port: multi-word write bursts with a per-word valid/ready handshake, split/retry handling, and grant/slave timeouts with an error pulse.

Parameters:
- SLAVE_LEN, 2, width of slave_select.
- ADDRESS_LEN, 12, width of address.
- WORD_SIZE, 8, data word width.
- BURST_SIZE, 12, width of burst_num; must be <= ADDRESS_LEN.
- TIMEOUT, 16, maximum wait cycles for approval_grant or slave_ready.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only when master_ready=1.
- instruction  in  2  2'b10 write, 2'b01 read; 00/11 ignored.
- slave_select  in  SLAVE_LEN  target slave.
- address  in  ADDRESS_LEN  start address.
- burst_num  in  BURST_SIZE  number of words minus 1.
- data  in  WORD_SIZE  write word.
- data_valid  in  1  data word available.
- data_ready  out  1  one-cycle accept pulse for data.
- approval_request  out  1  bus request to arbiter.
- approval_grant  in  1  arbiter grant.
- arbitor_busy  in  1  arbiter busy; request not raised while high.
- slave_ready  in  1  addressed slave ready.
- split_en  in  1  slave split request.
- rx_done  in  1  read data fully received by in-port.
- master_ready  out  1  idle, able to take a command.
- bus_busy  out  1  high from grant until DONE.
- master_valid  out  1  high while any tx_* bit is valid.
- write_en  out  1  held high for a write transaction.
- read_en  out  1  held high for a read transaction.
- tx_slave_select  out  1  serial slave select.
- tx_address  out  1  serial address.
- tx_burst_num  out  1  serial burst count.
- tx_data  out  1  serial write data.
- tx_done  out  1  one-cycle completion pulse.
- timeout_err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset: all outputs 0 except master_ready=1; state IDLE; counters cleared.
- Reset is honoured in any state, including mid-burst: the next cycle is IDLE with all tx_* lines at 0.
- IDLE:
  - master_ready=1.
  - On start with a valid instruction, latch instruction, slave_select, address and burst_num; master_ready drops next cycle.
  - Go to REQ.
  - start with instruction 00/11 is ignored.
- REQ:
  - approval_request=1 while arbitor_busy=0.
  - On approval_grant, bus_busy=1 and go to SEL.
  - A wait counter counts every REQ cycle. If it reaches TIMEOUT, pulse timeout_err, drop the request, and go to IDLE.
- SEL:
  - SLAVE_LEN cycles; tx_slave_select = latched bit i in cycle i (LSB first).
  - master_valid=1; write_en/read_en asserted per instruction from SEL onward.
- WAIT_SLAVE:
  - master_valid=0.
  - slave_ready=1 -> ADDR.
  - split_en=1 (priority over slave_ready in the same cycle) -> SPLIT.
  - TIMEOUT cycles with neither -> timeout_err, IDLE.
- SPLIT:
  - Drop approval_request, bus_busy, write_en and read_en.
  - Wait for split_en=0, then return to REQ with the counter cleared.
  - The latched command is retained, and the header is resent in full.
- ADDR:
  - ADDRESS_LEN cycles; tx_address = address bit i.
  - Concurrently, tx_burst_num = burst_num bit i for i < BURST_SIZE, then 0.
  - master_valid=1.
  - Then go to DATA for a write, RD_WAIT for a read.
- DATA (write):
  - Word loop: burst_num+1 words total. The word counter is BURST_SIZE+1 bits wide, so burst_num all-ones yields 2^BURST_SIZE words with no wrap.
  - Per word:
    - Wait for data_valid with master_valid=0.
    - Accept the word with data_ready=1 for exactly one cycle.
    - Shift it out over the following WORD_SIZE cycles, LSB first, with master_valid=1.
  - No gap is inserted when data_valid is already high; the next word's data_ready coincides with the last bit of the previous word.
  - After the last word, go to DONE.
- RD_WAIT: read_en held high; on rx_done go to DONE. There is no timeout here.
- DONE:
  - tx_done=1 for one cycle.
  - Clear approval_request, bus_busy, write_en and read_en.
  - master_ready=1 next cycle in IDLE.
- approval_grant deasserted after SEL has begun is ignored; the grant is assumed held until DONE.

Test Plan:
- Single write:
  - Stimulus: slave_select=2'b01, address=12'h005, burst_num=0, data=8'hA5, grant at cycle 2, slave_ready immediately.
  - Expected: tx_slave_select 1,0; tx_address 1,0,1,0…0; tx_data 1,0,1,0,0,1,0,1; tx_done once; write_en low after.
- Burst write:
  - Stimulus: burst_num=3, data 8'h01,8'h02,8'h03,8'h04 with data_valid held high.
  - Expected: exactly 4 data_ready pulses spaced 8 cycles apart, 32 contiguous data bits, tx_done 1 cycle after the last bit.
- Read:
  - Stimulus: instruction=01, address=12'hFFF, rx_done 20 cycles after ADDR.
  - Expected: read_en high from SEL through DONE, tx_data stays 0, tx_done on the cycle after rx_done.
- Grant timeout:
  - Stimulus: approval_grant never asserted.
  - Expected: timeout_err pulses after 16 REQ cycles, approval_request low, master_ready=1.
- Split/retry:
  - Stimulus: split_en=1 during WAIT_SLAVE for 5 cycles, then re-grant.
  - Expected: request drops, header is resent identically, and the transaction completes with a single tx_done.
- Reset mid-burst:
  - Stimulus: rst=1 during word 2 of a 4-word burst.
  - Expected: next cycle all outputs at reset values; a new command completes normally.
